// File: rtl/serial_rx_pkg.sv
// Types shared by the serial link: default word width, word type and the
// receiver holding-register states.
package serial_pkg;

   localparam int SERIAL_WIDTH_DEF = 8;

   typedef logic [SERIAL_WIDTH_DEF-1:0] serial_word_t;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

endpackage

// File: rtl/serial_rx_if.sv
// Link-side and consumer-side signals of the serial receiver. The master side
// drives the bit stream and the ack; the slave side is the receiver.
interface serial_rx_if
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH_DEF
);
   localparam int CW = $clog2(WIDTH);

   logic             i_in;
   logic             i_rxen;
   logic             i_clr;
   logic             i_ack;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             o_overrun;
   logic [CW-1:0]    o_count;

   modport master (
      output i_in, i_rxen, i_clr, i_ack,
      input  o_data, o_valid, o_overrun, o_count
   );

   modport slave (
      input  i_in, i_rxen, i_clr, i_ack,
      output o_data, o_valid, o_overrun, o_count
   );

endinterface

// File: rtl/serial_rx.sv
// MSB-first serial-to-parallel receiver feeding a valid/ack holding register,
// with a sticky overrun flag for words that arrive while the register is full.
module serial_rx
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH_DEF
) (
   input logic        i_clk,
   input logic        i_rst_n,
   serial_rx_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] word;
   logic [CW-1:0]    count_q, count_d;
   logic             overrun_q, overrun_d;
   logic             complete;
   hold_state_t      state_q, state_d;

   always_comb begin
      sh_d      = sh_q;
      count_d   = count_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      state_d   = state_q;
      complete  = 1'b0;
      word      = {sh_q[WIDTH-2:0], bus.i_in};

      // Clear wins over a strobe and an ack on the same edge; o_data is kept.
      if (bus.i_clr) begin
         sh_d      = '0;
         count_d   = '0;
         overrun_d = 1'b0;
         state_d   = HOLD_EMPTY;
      end else begin
         if (bus.i_rxen) begin
            sh_d = word;
            if (count_q == CW'(WIDTH - 1)) begin
               count_d  = '0;
               complete = 1'b1;
            end else begin
               count_d = count_q + CW'(1);
            end
         end

         case (state_q)
            HOLD_EMPTY: begin
               if (complete) begin
                  data_d  = word;
                  state_d = HOLD_FULL;
               end
            end
            HOLD_FULL: begin
               if (complete && bus.i_ack) begin
                  data_d = word;
               end else if (complete) begin
                  overrun_d = 1'b1;
               end else if (bus.i_ack) begin
                  state_d = HOLD_EMPTY;
               end
            end
            default: state_d = HOLD_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sh_q      <= '0;
         count_q   <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
         state_q   <= HOLD_EMPTY;
      end else begin
         sh_q      <= sh_d;
         count_q   <= count_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
      end
   end

   assign bus.o_data    = data_q;
   assign bus.o_valid   = (state_q == HOLD_FULL);
   assign bus.o_overrun = overrun_q;
   assign bus.o_count   = count_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: a word-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_serial_rx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       in_drv = 1'b0;
   logic       rxen_drv = 1'b0;
   logic       clr_drv = 1'b0;
   logic       ack_drv = 1'b0;
   logic       use_tx = 1'b0;

   logic       tx_load = 1'b0;
   logic       tx_en = 1'b0;
   logic [7:0] tx_word = 8'h00;
   logic [7:0] tx_sh = 8'h00;
   logic       tx_q = 1'b0;
   logic       txen_dly = 1'b0;

   int checks = 0;
   int errors = 0;

   int         m_bits = 0;
   int         m_acc = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_over = 1'b0;

   int         n_bits;
   int         n_acc;
   logic [7:0] n_data;
   logic       n_valid;
   logic       n_over;

   serial_rx_if #(.WIDTH(8)) bus ();

   serial_rx #(.WIDTH(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   assign bus.i_in   = use_tx ? tx_q : in_drv;
   assign bus.i_rxen = use_tx ? txen_dly : rxen_drv;
   assign bus.i_clr  = clr_drv;
   assign bus.i_ack  = ack_drv;

   // Minimal registered transmitter so loopback sees the real one-cycle skew.
   always @(posedge clk) begin
      txen_dly <= tx_en;
      if (tx_load) begin
         tx_sh <= tx_word;
      end else if (tx_en) begin
         tx_q  <= tx_sh[7];
         tx_sh <= {tx_sh[6:0], 1'b0};
      end
   end

   // Reference: bits accumulate arithmetically; every 8th bit yields a word.
   always_comb begin
      n_bits  = m_bits;
      n_acc   = m_acc;
      n_data  = m_data;
      n_valid = m_valid;
      n_over  = m_over;
      if (bus.i_clr === 1'b1) begin
         n_bits  = 0;
         n_acc   = 0;
         n_valid = 1'b0;
         n_over  = 1'b0;
      end else begin
         if (bus.i_rxen === 1'b1) begin
            n_acc  = m_acc * 2 + ((bus.i_in === 1'b1) ? 1 : 0);
            n_bits = m_bits + 1;
         end
         if (n_bits == 8) begin
            if (!m_valid || bus.i_ack === 1'b1) begin
               n_data  = n_acc[7:0];
               n_valid = 1'b1;
            end else begin
               n_over = 1'b1;
            end
            n_bits = 0;
            n_acc  = 0;
         end else if (bus.i_ack === 1'b1) begin
            n_valid = 1'b0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bits  <= 0;
         m_acc   <= 0;
         m_data  <= 8'h00;
         m_valid <= 1'b0;
         m_over  <= 1'b0;
      end else begin
         m_bits  <= n_bits;
         m_acc   <= n_acc;
         m_data  <= n_data;
         m_valid <= n_valid;
         m_over  <= n_over;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("model_data", 32'(bus.o_data), 32'(m_data));
         checkOutput("model_valid", 32'(bus.o_valid), 32'(m_valid));
         checkOutput("model_overrun", 32'(bus.o_overrun), 32'(m_over));
         checkOutput("model_count", 32'(bus.o_count), 32'(m_bits));
      end
   end

   task automatic applyStimulus(input logic in, input logic rxen, input logic clr,
                                input logic ack);
      in_drv   = in;
      rxen_drv = rxen;
      clr_drv  = clr;
      ack_drv  = ack;
      @(negedge clk);
   endtask

   task automatic sendWord(input logic [7:0] w, input int max_gap, input bit ack_last);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(w[i], 1'b1, 1'b0, ack_last && (i == 0));
         if (max_gap > 0 && i > 0) begin
            int gap;
            gap = $urandom_range(max_gap, 1);
            for (int k = 0; k < gap; k++) begin
               applyStimulus(1'bz, 1'b0, 1'b0, 1'b0);
            end
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("rst_data", 32'(bus.o_data), 32'h0);
      checkOutput("rst_valid", 32'(bus.o_valid), 32'h0);
      checkOutput("rst_overrun", 32'(bus.o_overrun), 32'h0);
      checkOutput("rst_count", 32'(bus.o_count), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] loopback 8'hA5");
      use_tx  = 1'b1;
      tx_word = 8'hA5;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      tx_en   = 1'b1;
      repeat (8) @(negedge clk);
      tx_en = 1'b0;
      checkOutput("loop_valid_early", 32'(bus.o_valid), 32'h0);
      checkOutput("loop_count_7", 32'(bus.o_count), 32'h7);
      @(negedge clk);
      checkOutput("loop_valid", 32'(bus.o_valid), 32'h1);
      checkOutput("loop_data", 32'(bus.o_data), 32'hA5);
      checkOutput("loop_overrun", 32'(bus.o_overrun), 32'h0);
      @(negedge clk);
      use_tx = 1'b0;

      $display("[TB] back-to-back 8'h3C, 8'hC3");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ack_empties", 32'(bus.o_valid), 32'h0);
      checkOutput("ack_keeps_data", 32'(bus.o_data), 32'hA5);
      sendWord(8'h3C, 0, 1'b0);
      checkOutput("b2b_first", 32'(bus.o_data), 32'h3C);
      checkOutput("b2b_first_valid", 32'(bus.o_valid), 32'h1);
      sendWord(8'hC3, 0, 1'b1);
      checkOutput("b2b_second", 32'(bus.o_data), 32'hC3);
      checkOutput("b2b_valid", 32'(bus.o_valid), 32'h1);
      checkOutput("b2b_overrun", 32'(bus.o_overrun), 32'h0);

      $display("[TB] overrun 8'h11, 8'h22");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      sendWord(8'h11, 0, 1'b0);
      checkOutput("ovr_no_flag_yet", 32'(bus.o_overrun), 32'h0);
      sendWord(8'h22, 0, 1'b0);
      checkOutput("ovr_data", 32'(bus.o_data), 32'h11);
      checkOutput("ovr_valid", 32'(bus.o_valid), 32'h1);
      checkOutput("ovr_flag", 32'(bus.o_overrun), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ovr_sticky", 32'(bus.o_overrun), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("clr_valid", 32'(bus.o_valid), 32'h0);
      checkOutput("clr_overrun", 32'(bus.o_overrun), 32'h0);
      checkOutput("clr_data", 32'(bus.o_data), 32'h11);

      $display("[TB] gapped 8'h96");
      sendWord(8'h96, 3, 1'b0);
      checkOutput("gap_data", 32'(bus.o_data), 32'h96);
      checkOutput("gap_valid", 32'(bus.o_valid), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] clear mid-frame then 8'h5A");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("mid_count_3", 32'(bus.o_count), 32'h3);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("clr_strobe_count", 32'(bus.o_count), 32'h0);
      sendWord(8'h5A, 0, 1'b0);
      checkOutput("after_clr_data", 32'(bus.o_data), 32'h5A);
      checkOutput("after_clr_valid", 32'(bus.o_valid), 32'h1);

      $display("[TB] async reset mid-frame");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("pre_rst_count", 32'(bus.o_count), 32'h2);
      #2;
      rxen_drv = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("arst_data", 32'(bus.o_data), 32'h0);
      checkOutput("arst_valid", 32'(bus.o_valid), 32'h0);
      checkOutput("arst_overrun", 32'(bus.o_overrun), 32'h0);
      checkOutput("arst_count", 32'(bus.o_count), 32'h0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      sendWord(8'hE7, 0, 1'b0);
      checkOutput("post_rst_data", 32'(bus.o_data), 32'hE7);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
